// File: rtl/jtdsp16_pkg.sv
// rtl/jtdsp16_pkg.sv - shared constants and state encoding for the DSP16 do/redo loop cache
package jtdsp16_pkg;

    localparam int DO_NI_MAX = 15;
    localparam int DO_KW     = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPLAY = 2'd2
    } do_state_t;

endpackage

// File: rtl/jtdsp16_cache_ram.sv
// rtl/jtdsp16_cache_ram.sv - loop body register file, one synchronous write port and one async read port
module jtdsp16_cache_ram #(
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Contents are deliberately left unreset; cache_valid guards every use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jtdsp16_do_cache.sv
// rtl/jtdsp16_do_cache.sv - do/redo loop controller: captures the loop body, replays it and holds the PC
module jtdsp16_do_cache
    import jtdsp16_pkg::*;
#(
    parameter int DEPTH = DO_NI_MAX,
    parameter int KW    = DO_KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          do_start,
    input  logic          redo_start,
    input  logic [3:0]    do_ni,
    input  logic [KW-1:0] do_k,
    input  logic [15:0]   rom_dout,
    output logic [15:0]   cache_dout,
    output logic          cache_sel,
    output logic          pc_hold,
    output logic          irq_mask,
    output logic          cache_valid,
    output logic          loop_done
);

    do_state_t     state;
    logic [3:0]    ni;
    logic [KW-1:0] iter;
    logic [3:0]    wr_ptr;
    logic [3:0]    cur_ptr;
    logic          done_q;
    logic [3:0]    raddr;
    logic [15:0]   rdata;
    logic          fill_last;
    logic          cur_last;

    assign fill_last = (wr_ptr == ni - 4'd1);
    assign cur_last  = (cur_ptr == ni - 4'd1);

    // Read address looks one word ahead so cache_dout is loaded with no bubble.
    always_comb begin
        raddr = 4'd0;
        if (state == REPLAY && !cur_last) begin
            raddr = cur_ptr + 4'd1;
        end
    end

    jtdsp16_cache_ram #(
        .DEPTH (DEPTH),
        .AW    (4)
    ) u_ram (
        .clk   (clk),
        .we    (cen && state == FILL),
        .waddr (wr_ptr),
        .wdata (rom_dout),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ni          <= 4'd0;
            iter        <= '0;
            wr_ptr      <= 4'd0;
            cur_ptr     <= 4'd0;
            cache_dout  <= 16'd0;
            cache_sel   <= 1'b0;
            cache_valid <= 1'b0;
            done_q      <= 1'b0;
        end else if (cen) begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_start && do_ni != 4'd0) begin
                        ni          <= do_ni;
                        iter        <= (do_k == '0) ? '0 : do_k - 1'b1;
                        wr_ptr      <= 4'd0;
                        cache_valid <= 1'b0;
                        state       <= FILL;
                    end else if (redo_start && cache_valid && do_k != '0) begin
                        iter       <= do_k;
                        cur_ptr    <= 4'd0;
                        cache_dout <= rdata;
                        cache_sel  <= 1'b1;
                        state      <= REPLAY;
                    end
                end
                FILL: begin
                    wr_ptr <= wr_ptr + 4'd1;
                    if (fill_last) begin
                        cache_valid <= 1'b1;
                        if (iter == '0) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            // A one-word body is being written this very edge.
                            cache_dout <= (ni == 4'd1) ? rom_dout : rdata;
                            cur_ptr    <= 4'd0;
                            cache_sel  <= 1'b1;
                            state      <= REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    if (!cur_last) begin
                        cur_ptr    <= cur_ptr + 4'd1;
                        cache_dout <= rdata;
                    end else if (iter == KW'(1)) begin
                        cache_sel <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        iter       <= iter - 1'b1;
                        cur_ptr    <= 4'd0;
                        cache_dout <= rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pc_hold   = (state == REPLAY);
    assign irq_mask  = (state != IDLE);
    assign loop_done = done_q & cen;

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// tb/tb_jtdsp16_do_cache.sv - scoreboard bench for the do/redo loop cache
module tb_jtdsp16_do_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        do_start;
    logic        redo_start;
    logic [3:0]  do_ni;
    logic [6:0]  do_k;
    logic [15:0] rom_dout;
    logic [15:0] cache_dout;
    logic        cache_sel;
    logic        pc_hold;
    logic        irq_mask;
    logic        cache_valid;
    logic        loop_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int irq_cnt = 0;
    int hold_cnt = 0;
    int d0, i0, h0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    jtdsp16_do_cache #(.DEPTH(15), .KW(7)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .do_start    (do_start),
        .redo_start  (redo_start),
        .do_ni       (do_ni),
        .do_k        (do_k),
        .rom_dout    (rom_dout),
        .cache_dout  (cache_dout),
        .cache_sel   (cache_sel),
        .pc_hold     (pc_hold),
        .irq_mask    (irq_mask),
        .cache_valid (cache_valid),
        .loop_done   (loop_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        d0 = done_cnt;
        i0 = irq_cnt;
        h0 = hold_cnt;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && irq_mask; i++) step();
        check({name, " idle timeout"}, {31'd0, irq_mask}, 32'd0);
        step();
    endtask

    task automatic counts(input string name, input int dd, input int di, input int dh);
        check({name, " loop_done pulses"}, done_cnt - d0, dd);
        check({name, " irq_mask cycles"}, irq_cnt - i0, di);
        check({name, " pc_hold cycles"}, hold_cnt - h0, dh);
        check({name, " queue drained"}, exp_q.size(), 0);
    endtask

    initial begin
        fork
            forever begin
                logic [15:0] w;
                @(negedge clk);
                if (rst_n && cen) begin
                    if (loop_done) done_cnt++;
                    if (irq_mask) irq_cnt++;
                    if (pc_hold) hold_cnt++;
                    if (cache_sel) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected replay word: got %0h expected none", cache_dout);
                        end else begin
                            w = exp_q.pop_front();
                            if (cache_dout !== w) begin
                                errors++;
                                $display("FAIL replay word: got %0h expected %0h", cache_dout, w);
                            end
                        end
                    end
                end
            end
        join_none

        rst_n = 1'b0; cen = 1'b1; do_start = 1'b0; redo_start = 1'b0;
        do_ni = 4'd0; do_k = 7'd0; rom_dout = 16'd0;
        step(); step();
        check("reset cache_dout", {16'd0, cache_dout}, 32'd0);
        check("reset cache_sel", {31'd0, cache_sel}, 32'd0);
        check("reset pc_hold", {31'd0, pc_hold}, 32'd0);
        check("reset irq_mask", {31'd0, irq_mask}, 32'd0);
        check("reset cache_valid", {31'd0, cache_valid}, 32'd0);
        check("reset loop_done", {31'd0, loop_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // redo with an empty cache does nothing
        redo_start = 1'b1; do_k = 7'd2;
        step();
        redo_start = 1'b0;
        check("redo empty irq_mask", {31'd0, irq_mask}, 32'd0);
        check("redo empty cache_sel", {31'd0, cache_sel}, 32'd0);
        step();

        // do K=3 NI=2 body A,B
        snap();
        exp_q.push_back(16'hA001); exp_q.push_back(16'hB002);
        exp_q.push_back(16'hA001); exp_q.push_back(16'hB002);
        do_start = 1'b1; do_ni = 4'd2; do_k = 7'd3;
        step();
        do_start = 1'b0;
        rom_dout = 16'hA001; step();
        check("fill pass-through cache_sel", {31'd0, cache_sel}, 32'd0);
        rom_dout = 16'hB002; step();
        rom_dout = 16'h5555;
        wait_idle("do3");
        counts("do3", 1, 6, 4);
        check("do3 cache_valid", {31'd0, cache_valid}, 32'd1);

        // redo K=2 replays A,B twice
        snap();
        exp_q.push_back(16'hA001); exp_q.push_back(16'hB002);
        exp_q.push_back(16'hA001); exp_q.push_back(16'hB002);
        redo_start = 1'b1; do_k = 7'd2;
        step();
        redo_start = 1'b0;
        wait_idle("redo2");
        counts("redo2", 1, 4, 4);

        // do with NI=0 is ignored
        do_start = 1'b1; do_ni = 4'd0; do_k = 7'd4;
        step();
        do_start = 1'b0;
        check("ni0 irq_mask", {31'd0, irq_mask}, 32'd0);
        check("ni0 cache_valid kept", {31'd0, cache_valid}, 32'd1);

        // do_start during REPLAY is ignored
        snap();
        exp_q.push_back(16'hC003); exp_q.push_back(16'hD004);
        exp_q.push_back(16'hC003); exp_q.push_back(16'hD004);
        do_start = 1'b1; do_ni = 4'd2; do_k = 7'd3;
        step();
        do_start = 1'b0;
        rom_dout = 16'hC003; step();
        rom_dout = 16'hD004; step();
        do_start = 1'b1; do_ni = 4'd3; do_k = 7'd5; rom_dout = 16'h7777;
        step();
        do_start = 1'b0;
        wait_idle("nested");
        counts("nested", 1, 6, 4);

        // cen toggling during REPLAY
        snap();
        exp_q.push_back(16'hE005); exp_q.push_back(16'hF006);
        exp_q.push_back(16'hE005); exp_q.push_back(16'hF006);
        do_start = 1'b1; do_ni = 4'd2; do_k = 7'd3;
        step();
        do_start = 1'b0;
        rom_dout = 16'hE005; step();
        rom_dout = 16'hF006; step();
        rom_dout = 16'h9999;
        for (int i = 0; i < 60 && irq_mask; i++) begin
            cen = ~cen;
            step();
        end
        cen = 1'b1;
        wait_idle("centog");
        counts("centog", 1, 6, 4);

        // do K=1 NI=15: single pass, no replay
        snap();
        do_start = 1'b1; do_ni = 4'd15; do_k = 7'd1;
        step();
        do_start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rom_dout = 16'h1000 + 16'(i);
            step();
        end
        check("ni15 loop_done", {31'd0, loop_done}, 32'd1);
        check("ni15 irq_mask", {31'd0, irq_mask}, 32'd0);
        check("ni15 cache_valid", {31'd0, cache_valid}, 32'd1);
        step();
        counts("ni15", 1, 15, 0);

        // reset in the middle of REPLAY
        exp_q.push_back(16'h6007); exp_q.push_back(16'h7008);
        do_start = 1'b1; do_ni = 4'd2; do_k = 7'd5;
        step();
        do_start = 1'b0;
        rom_dout = 16'h6007; step();
        rom_dout = 16'h7008; step();
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort cache_sel", {31'd0, cache_sel}, 32'd0);
        check("abort pc_hold", {31'd0, pc_hold}, 32'd0);
        check("abort irq_mask", {31'd0, irq_mask}, 32'd0);
        check("abort cache_valid", {31'd0, cache_valid}, 32'd0);
        check("abort cache_dout", {16'd0, cache_dout}, 32'd0);
        check("abort queue drained", exp_q.size(), 0);
        step(); step();
        rst_n = 1'b1;
        step();
        redo_start = 1'b1; do_k = 7'd2;
        step();
        redo_start = 1'b0;
        check("redo after abort irq_mask", {31'd0, irq_mask}, 32'd0);
        check("redo after abort cache_sel", {31'd0, cache_sel}, 32'd0);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
